// File: rtl/eth_rx_frame_buf.sv
// Receive frame buffer: bytes are written speculatively and committed or rolled
// back at Frame_End. Committed frames stream out with a length FIFO framing each.
module eth_rx_frame_buf #(
  parameter int pADDR_W    = 11,
  parameter int pMIN_LEN   = 64,
  parameter int pMAX_LEN   = 1518,
  parameter int pLEN_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Byte_Vld,
  input  logic [7:0]  Byte,
  input  logic        Frame_End,
  input  logic        Crc_Ok,
  output logic        Out_Valid,
  output logic [7:0]  Out_Data,
  output logic        Out_Last,
  input  logic        Out_Ready,
  output logic [15:0] Frame_Cnt,
  output logic [15:0] Drop_Cnt
);
  localparam int LW = 11;
  localparam int IW = (pLEN_DEPTH > 1) ? $clog2(pLEN_DEPTH) : 1;
  localparam int CW = $clog2(pLEN_DEPTH + 1);
  localparam logic [LW-1:0] MIN_L    = LW'(pMIN_LEN);
  localparam logic [LW-1:0] MAX_L    = LW'(pMAX_LEN);
  localparam logic [LW-1:0] SAT_L    = LW'(pMAX_LEN + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(pLEN_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(pLEN_DEPTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [7:0]         mem [2**pADDR_W];
  logic [7:0]         dout_q;

  logic [pADDR_W-1:0] wptr_q, wptr_d, cwptr_q, cwptr_d, rptr_q, rptr_d;
  logic [pADDR_W-1:0] wnext, wptr_eff, raddr;
  logic [LW-1:0]      len_q, len_d, len_eff, rem_q, rem_d;
  logic               ovf_q, ovf_d, ovf_eff;
  logic               buf_full, room, we, commit, drop;
  logic [1:0]         state_q, state_d;
  logic               acc, last, pop, ren;

  logic [LW-1:0]      lf_mem_q [pLEN_DEPTH];
  logic [IW-1:0]      lf_wr_q, lf_rd_q;
  logic [CW-1:0]      lf_cnt_q;
  logic               lf_full, lf_nempty;
  logic [LW-1:0]      lf_head;
  logic [15:0]        frame_cnt_q, drop_cnt_q;

  assign lf_full   = (lf_cnt_q == DEPTH_C);
  assign lf_nempty = (lf_cnt_q != '0);
  assign lf_head   = lf_mem_q[lf_rd_q];

  assign Out_Valid = (state_q == S_STREAM);
  assign Out_Last  = Out_Valid && last;
  assign Out_Data  = dout_q;
  assign Frame_Cnt = frame_cnt_q;
  assign Drop_Cnt  = drop_cnt_q;

  // Write side; a byte arriving with Frame_End is counted into the closing frame
  always_comb begin
    wnext    = wptr_q + 1'b1;
    buf_full = (wnext == rptr_q);
    room     = (len_q < MAX_L);
    we       = Byte_Vld && room && !ovf_q && !buf_full;
    ovf_eff  = ovf_q || (Byte_Vld && room && buf_full);
    len_eff  = len_q;
    if (Byte_Vld && len_q != SAT_L) len_eff = len_q + 1'b1;
    wptr_eff = we ? wnext : wptr_q;
    commit   = 1'b0;
    drop     = 1'b0;
    if (Frame_End && len_eff != '0) begin
      if (Crc_Ok && len_eff >= MIN_L && len_eff <= MAX_L && !ovf_eff && !lf_full)
        commit = 1'b1;
      else
        drop = 1'b1;
    end
    len_d   = Frame_End ? '0 : len_eff;
    ovf_d   = Frame_End ? 1'b0 : ovf_eff;
    wptr_d  = drop ? cwptr_q : wptr_eff;
    cwptr_d = commit ? wptr_eff : cwptr_q;
  end

  // Read side; rptr_q is the address of the byte on Out_Data, so it stays occupied
  always_comb begin
    acc     = Out_Valid && Out_Ready;
    last    = (rem_q == LW'(1));
    pop     = 1'b0;
    ren     = 1'b0;
    raddr   = rptr_q;
    state_d = state_q;
    rem_d   = rem_q;
    rptr_d  = rptr_q;
    case (state_q)
      S_IDLE: if (lf_nempty) begin
        pop     = 1'b1;
        rem_d   = lf_head;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        ren     = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: if (acc) begin
        rptr_d = rptr_q + 1'b1;
        if (last) begin
          if (lf_nempty) begin
            pop     = 1'b1;
            rem_d   = lf_head;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ren   = 1'b1;
          raddr = rptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (we) mem[wptr_q] <= Byte;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr_q      <= '0;
      cwptr_q     <= '0;
      rptr_q      <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
      rem_q       <= '0;
      dout_q      <= '0;
      lf_wr_q     <= '0;
      lf_rd_q     <= '0;
      lf_cnt_q    <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < pLEN_DEPTH; i++) lf_mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      cwptr_q <= cwptr_d;
      rptr_q  <= rptr_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      if (ren) dout_q <= mem[raddr];
      if (commit) begin
        lf_mem_q[lf_wr_q] <= len_eff;
        lf_wr_q <= (lf_wr_q == LAST_IDX) ? '0 : lf_wr_q + 1'b1;
      end
      if (pop) lf_rd_q <= (lf_rd_q == LAST_IDX) ? '0 : lf_rd_q + 1'b1;
      case ({commit, pop})
        2'b10:   lf_cnt_q <= lf_cnt_q + 1'b1;
        2'b01:   lf_cnt_q <= lf_cnt_q - 1'b1;
        default: lf_cnt_q <= lf_cnt_q;
      endcase
      if (commit && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Bench for eth_rx_frame_buf: byte scoreboards for a default instance (A) and a
// 128-byte-buffer instance (B), plus a table of single frames and corner sequences.
module tb_eth_rx_frame_buf;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Byte_Vld = 1'b0, Frame_End = 1'b0, Crc_Ok = 1'b0, Out_Ready = 1'b1;
  logic [7:0]  Byte = 8'h00;
  logic        a_vld, a_last, b_vld, b_last;
  logic [7:0]  a_data, b_data;
  logic [15:0] a_fc, a_dc, b_fc, b_dc;

  always #5 Clk = ~Clk;

  eth_rx_frame_buf dut_a (
    .Clk(Clk), .Rst(Rst), .Byte_Vld(Byte_Vld), .Byte(Byte), .Frame_End(Frame_End),
    .Crc_Ok(Crc_Ok), .Out_Valid(a_vld), .Out_Data(a_data), .Out_Last(a_last),
    .Out_Ready(Out_Ready), .Frame_Cnt(a_fc), .Drop_Cnt(a_dc));

  eth_rx_frame_buf #(.pADDR_W(7)) dut_b (
    .Clk(Clk), .Rst(Rst), .Byte_Vld(Byte_Vld), .Byte(Byte), .Frame_End(Frame_End),
    .Crc_Ok(Crc_Ok), .Out_Valid(b_vld), .Out_Data(b_data), .Out_Last(b_last),
    .Out_Ready(Out_Ready), .Frame_Cnt(b_fc), .Drop_Cnt(b_dc));

  int         n_chk = 0, n_fail = 0;
  int         exp_fc = 0, exp_dc = 0, lasts_a = 0;
  logic [8:0] qa[$], qb[$];
  logic [8:0] wa, wb, pa_word, pb_word;
  logic       pa_stall = 1'b0, pb_stall = 1'b0;
  bit         chk_a = 1'b1, chk_b = 1'b0;

  typedef struct { int len; bit crc; bit fe_sep; logic [7:0] base; bit commit; } frame_t;
  frame_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input bit to_b, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      logic [8:0] w;
      w = {i == len - 1, base + 8'(i)};
      if (to_b) qb.push_back(w); else qa.push_back(w);
    end
  endtask

  task automatic send_frame(input int len, input bit crc, input logic [7:0] base, input bit fe_sep);
    for (int i = 0; i < len; i++) begin
      Byte_Vld  = 1'b1;
      Byte      = base + 8'(i);
      Frame_End = !fe_sep && (i == len - 1);
      Crc_Ok    = crc;
      @(posedge Clk); #1;
    end
    Byte_Vld = 1'b0;
    if (fe_sep) begin
      Frame_End = 1'b1;
      Crc_Ok    = crc;
      @(posedge Clk); #1;
    end
    Frame_End = 1'b0;
    Crc_Ok    = 1'b0;
  endtask

  task automatic wait_drain(input bit on_b, input string name);
    int n;
    n = 0;
    while (n < 5000 && ((on_b ? qb.size() : qa.size()) != 0 || (on_b ? b_vld : a_vld))) begin
      @(posedge Clk); #1;
      n++;
    end
    n_chk++;
    if (n >= 5000) begin
      n_fail++;
      $display("FAIL %s: drain timeout, %0d bytes still expected", name, on_b ? qb.size() : qa.size());
    end
    repeat (3) @(posedge Clk);
    #1;
  endtask

  // Monitors: compare accepted bytes and require a stalled byte to hold
  always @(negedge Clk) begin
    if (!Rst && chk_a) begin
      if (pa_stall) begin
        check("a_hold_vld", 32'(a_vld), 32'd1);
        check("a_hold_word", 32'({a_last, a_data}), 32'(pa_word));
      end
      if (a_vld && Out_Ready) begin
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_unexpected: got byte 0x%0h last %0d, expected no output", a_data, a_last);
        end else begin
          wa = qa.pop_front();
          check("a_byte", 32'({a_last, a_data}), 32'(wa));
        end
        if (a_last) lasts_a++;
      end
      pa_stall <= a_vld && !Out_Ready;
      pa_word  <= {a_last, a_data};
    end else begin
      pa_stall <= 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (!Rst && chk_b) begin
      if (pb_stall) begin
        check("b_hold_vld", 32'(b_vld), 32'd1);
        check("b_hold_word", 32'({b_last, b_data}), 32'(pb_word));
      end
      if (b_vld && Out_Ready) begin
        if (qb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_unexpected: got byte 0x%0h last %0d, expected no output", b_data, b_last);
        end else begin
          wb = qb.pop_front();
          check("b_byte", 32'({b_last, b_data}), 32'(wb));
        end
      end
      pb_stall <= b_vld && !Out_Ready;
      pb_word  <= {b_last, b_data};
    end else begin
      pb_stall <= 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cv;
    tbl[0] = '{70,   1'b0, 1'b0, 8'h80, 1'b0};
    tbl[1] = '{64,   1'b1, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{63,   1'b1, 1'b0, 8'h20, 1'b0};
    tbl[3] = '{1519, 1'b1, 1'b0, 8'h30, 1'b0};
    tbl[4] = '{1518, 1'b1, 1'b0, 8'h11, 1'b1};
    tbl[5] = '{64,   1'b1, 1'b1, 8'hC0, 1'b1};
    tbl[6] = '{100,  1'b0, 1'b1, 8'h07, 1'b0};
    tbl[7] = '{65,   1'b1, 1'b0, 8'h40, 1'b1};

    repeat (3) @(posedge Clk);
    #1;
    check("rst_vld",  32'(a_vld),  32'd0);
    check("rst_last", 32'(a_last), 32'd0);
    check("rst_data", 32'(a_data), 32'd0);
    check("rst_fc",   32'(a_fc),   32'd0);
    check("rst_dc",   32'(a_dc),   32'd0);
    check("rst_b_vld", 32'(b_vld), 32'd0);
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // First frame: Out_Valid rises two edges after the committing Frame_End edge
    expect_frame(1'b0, 64, 8'h00);
    send_frame(64, 1'b1, 8'h00, 1'b0);
    check("lat_e0", 32'(a_vld), 32'd0);
    @(posedge Clk); #1;
    check("lat_e1", 32'(a_vld), 32'd0);
    @(posedge Clk); #1;
    check("lat_e2", 32'(a_vld), 32'd1);
    cv = 0;
    for (int i = 0; i < 64; i++) begin
      cv += int'(a_vld);
      @(posedge Clk); #1;
    end
    check("contiguous", 32'(cv), 32'd64);
    check("lat_fc", 32'(a_fc), 32'd1);
    exp_fc = 1;
    wait_drain(1'b0, "drain_first");

    foreach (tbl[i]) begin
      if (tbl[i].commit) begin
        expect_frame(1'b0, tbl[i].len, tbl[i].base);
        exp_fc++;
      end else begin
        exp_dc++;
      end
      send_frame(tbl[i].len, tbl[i].crc, tbl[i].base, tbl[i].fe_sep);
      wait_drain(1'b0, $sformatf("drain_tbl%0d", i));
      check($sformatf("tbl%0d_fc", i), 32'(a_fc), 32'(exp_fc));
      check($sformatf("tbl%0d_dc", i), 32'(a_dc), 32'(exp_dc));
    end

    // Frame_End with no bytes is ignored
    Frame_End = 1'b1; Crc_Ok = 1'b1;
    @(posedge Clk); #1;
    Frame_End = 1'b0; Crc_Ok = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("empty_fe_fc",  32'(a_fc),  32'(exp_fc));
    check("empty_fe_dc",  32'(a_dc),  32'(exp_dc));
    check("empty_fe_vld", 32'(a_vld), 32'd0);

    // Backpressure: the reader pops frame 0's length and holds it, so frames 1-4
    // fill the 4-entry length FIFO and frame 5 is the one dropped.
    Out_Ready = 1'b0;
    lasts_a   = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        expect_frame(1'b0, 64, 8'(k * 16'h40));
        exp_fc++;
      end else begin
        exp_dc++;
      end
      send_frame(64, 1'b1, 8'(k * 16'h40), 1'b0);
      repeat (2) @(posedge Clk);
      #1;
    end
    check("bp_fc",  32'(a_fc),  32'(exp_fc));
    check("bp_dc",  32'(a_dc),  32'(exp_dc));
    check("bp_vld", 32'(a_vld), 32'd1);
    Out_Ready = 1'b1;
    wait_drain(1'b0, "drain_bp");
    check("bp_lasts", 32'(lasts_a), 32'd5);

    // Reset mid-stream, then reset mid-frame; next good frame must come out clean
    expect_frame(1'b0, 64, 8'h55);
    send_frame(64, 1'b1, 8'h55, 1'b0);
    repeat (12) @(posedge Clk);
    #1;
    Rst = 1'b1;
    qa.delete();
    #1;
    check("mrst_vld",  32'(a_vld),  32'd0);
    check("mrst_last", 32'(a_last), 32'd0);
    check("mrst_data", 32'(a_data), 32'd0);
    check("mrst_fc",   32'(a_fc),   32'd0);
    check("mrst_dc",   32'(a_dc),   32'd0);
    exp_fc = 0;
    exp_dc = 0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      Byte_Vld = 1'b1;
      Byte     = 8'hEE;
      @(posedge Clk); #1;
    end
    Byte_Vld = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    expect_frame(1'b0, 64, 8'h33);
    exp_fc = 1;
    send_frame(64, 1'b1, 8'h33, 1'b0);
    wait_drain(1'b0, "drain_after_rst");
    check("post_rst_fc", 32'(a_fc), 32'(exp_fc));
    check("post_rst_dc", 32'(a_dc), 32'(exp_dc));

    // Small 128-byte buffer: second 100-byte frame overflows, later frames wrap
    Rst = 1'b1;
    chk_a = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk_b = 1'b1;
    @(posedge Clk); #1;
    Out_Ready = 1'b0;
    expect_frame(1'b1, 100, 8'h00);
    send_frame(100, 1'b1, 8'h00, 1'b0);
    send_frame(100, 1'b1, 8'h64, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    check("ovf_fc", 32'(b_fc), 32'd1);
    check("ovf_dc", 32'(b_dc), 32'd1);
    Out_Ready = 1'b1;
    wait_drain(1'b1, "drain_ovf");
    for (int k = 0; k < 5; k++) begin
      expect_frame(1'b1, 100, 8'(k * 37 + 5));
      send_frame(100, 1'b1, 8'(k * 37 + 5), 1'b0);
      wait_drain(1'b1, $sformatf("drain_wrap%0d", k));
    end
    check("wrap_fc", 32'(b_fc), 32'd6);
    check("wrap_dc", 32'(b_dc), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
